// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: grants up to NUM_CDB producers per cycle onto registered CDB slots.
// Optional per-requester grant and stall counters are enabled by defining CDB_ARB_PERF_CNT_EN.
module cdb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_CDB   = 2,
    parameter int TAG_W     = 7,
    parameter int DATA_W    = 32,
    parameter int ROB_TAG_W = 5
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*TAG_W-1:0]             req_phy_reg,
    input  logic [NUM_REQ*DATA_W-1:0]            req_data,
    input  logic [NUM_REQ*ROB_TAG_W-1:0]         req_rob_tag,
    input  logic [NUM_REQ-1:0]                   req_wr_en,
    output logic [NUM_CDB-1:0]                   cdb_valid,
    output logic [NUM_CDB*TAG_W-1:0]             cdb_phy_reg,
    output logic [NUM_CDB*DATA_W-1:0]            cdb_data,
    output logic [NUM_CDB*ROB_TAG_W-1:0]         cdb_rob_tag,
    output logic [NUM_CDB-1:0]                   cdb_wr_en,
    output logic [NUM_CDB*$clog2(NUM_REQ)-1:0]   cdb_src_id
`ifdef CDB_ARB_PERF_CNT_EN
    ,
    output logic [NUM_REQ*16-1:0]                grant_cnt,
    output logic [15:0]                          stall_cnt
`endif
);

    localparam int SRC_W = $clog2(NUM_REQ);

    logic [SRC_W-1:0]                r_rr_ptr;
    logic [NUM_CDB-1:0]              r_cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]        r_cdb_phy_reg;
    logic [NUM_CDB*DATA_W-1:0]       r_cdb_data;
    logic [NUM_CDB*ROB_TAG_W-1:0]    r_cdb_rob_tag;
    logic [NUM_CDB-1:0]              r_cdb_wr_en;
    logic [NUM_CDB*SRC_W-1:0]        r_cdb_src_id;

    logic [NUM_REQ-1:0]              w_grant;
    logic [NUM_CDB-1:0]              w_slot_vld;
    logic [NUM_CDB-1:0][SRC_W-1:0]   w_slot_src;
    logic [SRC_W-1:0]                w_last;
    logic [SRC_W-1:0]                w_ptr_nxt;
    logic                            w_any;

    // Scan from the pointer with wrap; the k-th hit takes slot k.
    always_comb begin
        int w_cnt;
        int w_idx;
        w_grant    = '0;
        w_slot_vld = '0;
        w_slot_src = '0;
        w_last     = '0;
        w_any      = 1'b0;
        w_cnt      = 0;
        w_idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (req_valid[w_idx] && (w_cnt < NUM_CDB)) begin
                w_grant[w_idx]    = 1'b1;
                w_slot_vld[w_cnt] = 1'b1;
                w_slot_src[w_cnt] = SRC_W'(w_idx);
                w_last            = SRC_W'(w_idx);
                w_any             = 1'b1;
                w_cnt             = w_cnt + 1;
            end
        end
    end

    assign w_ptr_nxt = (w_last == SRC_W'(NUM_REQ - 1)) ? '0 : w_last + 1'b1;
    assign req_ready = w_grant & {NUM_REQ{~flush & ~reset}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr      <= '0;
            r_cdb_valid   <= '0;
            r_cdb_phy_reg <= '0;
            r_cdb_data    <= '0;
            r_cdb_rob_tag <= '0;
            r_cdb_wr_en   <= '0;
            r_cdb_src_id  <= '0;
        end else if (flush) begin
            r_cdb_valid <= '0;
        end else begin
            r_cdb_valid <= w_slot_vld;
            for (int s = 0; s < NUM_CDB; s++) begin
                if (w_slot_vld[s]) begin
                    r_cdb_phy_reg[s*TAG_W +: TAG_W] <=
                        req_phy_reg[int'(w_slot_src[s])*TAG_W +: TAG_W];
                    r_cdb_data[s*DATA_W +: DATA_W] <=
                        req_data[int'(w_slot_src[s])*DATA_W +: DATA_W];
                    r_cdb_rob_tag[s*ROB_TAG_W +: ROB_TAG_W] <=
                        req_rob_tag[int'(w_slot_src[s])*ROB_TAG_W +: ROB_TAG_W];
                    r_cdb_wr_en[s] <= req_wr_en[w_slot_src[s]];
                    r_cdb_src_id[s*SRC_W +: SRC_W] <= w_slot_src[s];
                end
            end
            if (w_any) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    assign cdb_valid   = r_cdb_valid;
    assign cdb_phy_reg = r_cdb_phy_reg;
    assign cdb_data    = r_cdb_data;
    assign cdb_rob_tag = r_cdb_rob_tag;
    assign cdb_wr_en   = r_cdb_wr_en;
    assign cdb_src_id  = r_cdb_src_id;

`ifdef CDB_ARB_PERF_CNT_EN
    logic [NUM_REQ*16-1:0] r_grant_cnt;
    logic [15:0]           r_stall_cnt;
    logic                  w_stall;

    assign w_stall = |(req_valid & ~w_grant);

    // req_ready is already masked by flush, so accepted counts freeze too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && (r_grant_cnt[i*16 +: 16] != 16'hFFFF)) begin
                    r_grant_cnt[i*16 +: 16] <= r_grant_cnt[i*16 +: 16] + 16'd1;
                end
            end
            if (!flush && w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign grant_cnt = r_grant_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter (NUM_REQ=4, NUM_CDB=2).
module tb_cdb_arbiter;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [27:0] req_phy_reg;
    logic [127:0] req_data;
    logic [19:0] req_rob_tag;
    logic [3:0]  req_wr_en;
    logic [1:0]  cdb_valid;
    logic [13:0] cdb_phy_reg;
    logic [63:0] cdb_data;
    logic [9:0]  cdb_rob_tag;
    logic [1:0]  cdb_wr_en;
    logic [3:0]  cdb_src_id;
`ifdef CDB_ARB_PERF_CNT_EN
    logic [63:0] grant_cnt;
    logic [15:0] stall_cnt;
`endif

    int n_checks;
    int n_fail;

    cdb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_phy_reg (req_phy_reg),
        .req_data    (req_data),
        .req_rob_tag (req_rob_tag),
        .req_wr_en   (req_wr_en),
        .cdb_valid   (cdb_valid),
        .cdb_phy_reg (cdb_phy_reg),
        .cdb_data    (cdb_data),
        .cdb_rob_tag (cdb_rob_tag),
        .cdb_wr_en   (cdb_wr_en),
        .cdb_src_id  (cdb_src_id)
`ifdef CDB_ARB_PERF_CNT_EN
        ,
        .grant_cnt   (grant_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [6:0] phy,
                           input logic [31:0] dat, input logic [4:0] rob,
                           input logic we);
        req_phy_reg[i*7 +: 7]   = phy;
        req_data[i*32 +: 32]    = dat;
        req_rob_tag[i*5 +: 5]   = rob;
        req_wr_en[i]            = we;
    endtask

    task automatic default_payload();
        for (int i = 0; i < 4; i++) begin
            set_req(i, 7'(10 + i), 32'hA000_0000 + 32'(i), 5'(i), 1'b1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = 4'b0000;
        flush = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        default_payload();
        do_reset();
        req_valid = 4'b1111;
        @(posedge clk);
        @(posedge clk);
        #2;
        n_checks++;
        if (cdb_valid !== 2'b11) begin
            n_fail++;
            $display("FAIL pre_reset_valid got=%b exp=%b", cdb_valid, 2'b11);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (cdb_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset_valid got=%b exp=%b", cdb_valid, 2'b00);
        end
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready got=%b exp=%b", req_ready, 4'b0000);
        end
        n_checks++;
        if (cdb_src_id !== 4'h0 || cdb_data !== 64'h0 || cdb_phy_reg !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_payload got src=%h data=%h phy=%h exp=0",
                     cdb_src_id, cdb_data, cdb_phy_reg);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 4'b0011) begin
            n_fail++;
            $display("FAIL post_reset_ready got=%b exp=%b", req_ready, 4'b0011);
        end
        @(negedge clk);
        n_checks++;
        if (cdb_valid !== 2'b11 || cdb_src_id !== 4'b0100) begin
            n_fail++;
            $display("FAIL post_reset_cdb got v=%b src=%b exp v=11 src=0100",
                     cdb_valid, cdb_src_id);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy [4];
        logic [3:0] exp_src [4];
        logic [31:0] exp_d0 [4];
        exp_rdy = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
        exp_src = '{4'b0100, 4'b1110, 4'b0100, 4'b1110};
        exp_d0  = '{32'hA000_0000, 32'hA000_0002, 32'hA000_0000, 32'hA000_0002};
        default_payload();
        do_reset();
        req_valid = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if (req_ready !== exp_rdy[c]) begin
                n_fail++;
                $display("FAIL rr_ready[%0d] got=%b exp=%b", c, req_ready, exp_rdy[c]);
            end
            @(negedge clk);
            if (c == 3) req_valid = 4'b0000;
            n_checks++;
            if (cdb_valid !== 2'b11 || cdb_src_id !== exp_src[c] ||
                cdb_data[31:0] !== exp_d0[c]) begin
                n_fail++;
                $display("FAIL rr_cdb[%0d] got v=%b src=%b d0=%h exp v=11 src=%b d0=%h",
                         c, cdb_valid, cdb_src_id, cdb_data[31:0], exp_src[c], exp_d0[c]);
            end
        end
        @(negedge clk);
        n_checks++;
        if (cdb_valid !== 2'b00 || cdb_data[31:0] !== 32'hA000_0002) begin
            n_fail++;
            $display("FAIL idle_hold got v=%b d0=%h exp v=00 d0=a0000002",
                     cdb_valid, cdb_data[31:0]);
        end
    endtask

    task automatic test_single();
        set_req(2, 7'd9, 32'hDEAD_BEEF, 5'd3, 1'b1);
        req_valid = 4'b0100;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_ready got=%b exp=%b", req_ready, 4'b0100);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        n_checks++;
        if (cdb_valid !== 2'b01 || cdb_phy_reg[6:0] !== 7'd9 ||
            cdb_data[31:0] !== 32'hDEAD_BEEF || cdb_rob_tag[4:0] !== 5'd3 ||
            cdb_wr_en[0] !== 1'b1 || cdb_src_id[1:0] !== 2'd2) begin
            n_fail++;
            $display("FAIL single_cdb got v=%b phy=%0d d=%h rob=%0d we=%b src=%0d exp 01/9/deadbeef/3/1/2",
                     cdb_valid, cdb_phy_reg[6:0], cdb_data[31:0], cdb_rob_tag[4:0],
                     cdb_wr_en[0], cdb_src_id[1:0]);
        end
    endtask

    task automatic test_wrap();
        set_req(0, 7'd20, 32'h0000_1111, 5'd7, 1'b0);
        set_req(3, 7'd23, 32'h0000_3333, 5'd9, 1'b1);
        req_valid = 4'b1001;
        #1;
        n_checks++;
        if (req_ready !== 4'b1001) begin
            n_fail++;
            $display("FAIL wrap_ready got=%b exp=%b", req_ready, 4'b1001);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        n_checks++;
        if (cdb_valid !== 2'b11 || cdb_src_id !== 4'b0011 ||
            cdb_data !== {32'h0000_1111, 32'h0000_3333} || cdb_wr_en !== 2'b01 ||
            cdb_phy_reg !== {7'd20, 7'd23} || cdb_rob_tag !== {5'd7, 5'd9}) begin
            n_fail++;
            $display("FAIL wrap_cdb got v=%b src=%b d=%h we=%b exp v=11 src=0011 d=0000111100003333 we=01",
                     cdb_valid, cdb_src_id, cdb_data, cdb_wr_en);
        end
    endtask

    task automatic test_flush();
        default_payload();
        req_valid = 4'b1111;
        flush = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_ready got=%b exp=%b", req_ready, 4'b0000);
        end
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (cdb_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_cdb got=%b exp=%b", cdb_valid, 2'b00);
        end
        #1;
        n_checks++;
        if (req_ready !== 4'b0110) begin
            n_fail++;
            $display("FAIL flush_resume_ready got=%b exp=%b", req_ready, 4'b0110);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        n_checks++;
        if (cdb_valid !== 2'b11 || cdb_src_id !== 4'b1001) begin
            n_fail++;
            $display("FAIL flush_resume_cdb got v=%b src=%b exp v=11 src=1001",
                     cdb_valid, cdb_src_id);
        end
    endtask

`ifdef CDB_ARB_PERF_CNT_EN
    task automatic test_perf();
        default_payload();
        do_reset();
        req_valid = 4'b1111;
        repeat (10) @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (grant_cnt[i*16 +: 16] !== 16'd5) begin
                n_fail++;
                $display("FAIL grant_cnt[%0d] got=%0d exp=5", i, grant_cnt[i*16 +: 16]);
            end
        end
        n_checks++;
        if (stall_cnt !== 16'd10) begin
            n_fail++;
            $display("FAIL stall_cnt got=%0d exp=10", stall_cnt);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        flush = 1'b0;
        req_valid = 4'b0000;
        req_phy_reg = '0;
        req_data = '0;
        req_rob_tag = '0;
        req_wr_en = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_wrap();
        test_flush();
`ifdef CDB_ARB_PERF_CNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the common data bus (CDB) between all functional-unit result producers (ALUs, then MEM units) in the OOO core.
- Each cycle, grants up to NUM_CDB requesters in round-robin order and broadcasts their results on registered CDB slots.
- Consumers are the RS wakeup logic, the ROB and the physical register file write port.
- Sits between FU_UNIT_WRAPPER result outputs and the CDB_IF master side.

Parameters:
- NUM_REQ, 4, number of result producers (ALUs at indices 0..NUM_OF_ALUS-1, MEM units above); must be >= 2.
- NUM_CDB, 2, CDB broadcast slots per cycle; 1 <= NUM_CDB <= NUM_REQ.
- TAG_W, 7, physical register tag width.
- DATA_W, 32, result data width.
- ROB_TAG_W, 5, ROB index width.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  branch-mispredict flush
- req_valid  in  NUM_REQ  producer has a result
- req_ready  out  NUM_REQ  result accepted this cycle
- req_phy_reg  in  NUM_REQ*TAG_W  destination physical register per producer
- req_data  in  NUM_REQ*DATA_W  result value
- req_rob_tag  in  NUM_REQ*ROB_TAG_W  ROB entry of the producing instruction
- req_wr_en  in  NUM_REQ  result writes a register (0 for stores/branches)
- cdb_valid  out  NUM_CDB  slot carries a result
- cdb_phy_reg  out  NUM_CDB*TAG_W  broadcast tag
- cdb_data  out  NUM_CDB*DATA_W  broadcast value
- cdb_rob_tag  out  NUM_CDB*ROB_TAG_W  broadcast ROB index
- cdb_wr_en  out  NUM_CDB  broadcast write enable
- cdb_src_id  out  NUM_CDB*$clog2(NUM_REQ)  index of the granted producer

Behaviour:
- State is the round-robin pointer rr_ptr ($clog2(NUM_REQ) bits) plus the registered CDB slot outputs.
- Grant (combinational):
  - Scan requesters rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - The first NUM_CDB with req_valid=1 are granted.
  - The k-th granted requester in scan order is assigned slot k.
- req_ready[i] = granted[i].
  - A transfer occurs when valid & ready.
  - Producers hold valid and payload stable until ready.
  - req_ready is 0 for non-valid requesters.
- Latency: a result accepted in cycle N appears on cdb_* in cycle N+1 (one register stage).
- Slots with no grant in cycle N have cdb_valid=0 in N+1. Their payload is don't-care but held at the previous value.
- Pointer update:
  - If any grant, rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
  - Otherwise rr_ptr holds.
- Wrap-around: the scan crosses index NUM_REQ-1 to 0 without a gap.
- Fairness: a continuously valid requester is granted within ceil(NUM_REQ/NUM_CDB) cycles.
- If the valid count <= NUM_CDB, all valid requesters are granted in the same cycle.
- Flush=1:
  - All req_ready forced to 0 that cycle.
  - cdb_valid <= 0 on the next edge.
  - rr_ptr holds.
  - Results already registered (cycle N) still broadcast in N+1 only if flush was low in N.
- Reset (asynchronous, any time, including mid-transfer):
  - cdb_valid=0, cdb_* payload=0, cdb_src_id=0, rr_ptr=0, req_ready=0 while reset is high.
  - Normal arbitration resumes on the first edge after deassertion.
- No internal buffering: the arbiter never drops a result. Backpressure is only via req_ready.

Optional Feature:
- Macro: CDB_ARB_PERF_CNT_EN.
- Defined: adds outputs
  - grant_cnt (NUM_REQ*16): per-requester accepted-result count.
  - stall_cnt (16): cycles in which at least one valid requester was not granted.
  - All counters saturate at 16'hFFFF, clear on reset only, and do not increment while flush=1.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan (NUM_REQ=4, NUM_CDB=2):
1. Assert reset mid-traffic with all 4 requesters valid -> cdb_valid=2'b00 immediately (asynchronous), req_ready=0. After release, the first grants go to {0,1}.
2. All 4 requesters valid continuously for 4 cycles -> grant sets {0,1},{2,3},{0,1},{2,3}. On the following cycles, cdb_src_id slot0/slot1 = 0/1, 2/3, 0/1, 2/3 and cdb_valid=2'b11.
3. Only requester 2 valid (phy_reg=9, data=32'hDEADBEEF, rob_tag=3, wr_en=1) -> req_ready=4'b0100 the same cycle. Next cycle: cdb_valid=2'b01, slot0 carries tag 9, 32'hDEADBEEF, rob 3, src_id 2. rr_ptr becomes 3.
4. Wrap-around: rr_ptr=3 with requesters 0 and 3 valid -> slot0=3, slot1=0, rr_ptr becomes 1.
5. Flush asserted while all requesters are valid -> req_ready=0. Next cycle cdb_valid=0 and rr_ptr unchanged. After flush deasserts, grants resume from the same rr_ptr.
6. With CDB_ARB_PERF_CNT_EN, all 4 valid for 10 cycles after reset -> grant_cnt={5,5,5,5}, stall_cnt=10. Without the macro, the build has no counter ports and test 2 results are identical.
